// File: rtl/serial_add_unit.sv
// serial_add_unit
//
// Bit-serial adder with valid/ready handshakes on both sides. It produces
// {cout,sum} = a + b + cin using one full-adder cell, one bit per clock,
// LSB first. For WIDTH=4 the result matches a parallel 4-bit full adder.
//
// Optional feature: define SERIAL_ADD_SAT_EN to saturate the sum to all ones
// whenever the final carry is set (cout is still reported as 1).
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand tuple a/b/cin valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       WIDTH-bit operands
//   cin        carry-in
//   out_valid  sum/cout valid (DONE only)
//   out_ready  consumer accepts the result
//   sum        WIDTH-bit registered result
//   cout       registered carry-out of the MSB
//   busy       high while bits are being shifted

module serial_add_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic             bit_s;
  logic             bit_c;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] final_sum;

  // One full-adder cell fed by the operand LSBs and the carry flop. The new
  // sum bit enters the accumulator at the MSB end, so after WIDTH shifts the
  // first (least significant) bit has arrived at position 0.
  always_comb begin
    bit_s    = a_sh[0] ^ b_sh[0] ^ carry;
    bit_c    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
    acc_next = {bit_s, acc[WIDTH-1:1]};
  end

  // Value loaded into the visible sum register on entry to DONE. The
  // saturating build replaces an overflowed result with all ones.
  always_comb begin
`ifdef SERIAL_ADD_SAT_EN
    final_sum = bit_c ? {WIDTH{1'b1}} : acc_next;
`else
    final_sum = acc_next;
`endif
  end

  // Status outputs are pure decodes of the state register, so no input
  // reaches an output without passing through a flop.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);

  // Control FSM and datapath. The visible sum/cout registers are only
  // written on the final shift cycle, so a partial result is never shown
  // and the last result stays on the outputs until a new one replaces it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            acc   <= '0;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          acc   <= acc_next;
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= bit_c;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_BIT) begin
            sum   <= final_sum;
            cout  <= bit_c;
            state <= DONE;
          end
        end
        DONE: begin
          // New operands presented here are not taken; they wait for IDLE.
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_unit.md
# serial_add_unit

Bit-serial, handshaked adder that computes a WIDTH-bit sum and carry-out over WIDTH cycles using a single one-bit full-adder cell (XOR/AND/OR). It sits directly upstream of the gate-level checkers and downstream of operand sources. For WIDTH=4 its result is bit-exact with the parallel 4-bit `full_adder`, so the two are interchangeable where area matters more than latency.

## Interface
Parameters:
- WIDTH, 4, operand and sum width in bits; legal range 2..16.

Ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand tuple a/b/cin is valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, registered.
- cout  output  1  carry-out of the MSB, registered.
- busy  output  1  high in SHIFT.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. When in_valid=1 at the clock edge, load a and b into shift registers, load cin into the carry flop, clear the bit counter, and go to SHIFT.
- SHIFT: each cycle, take the operand LSBs and the carry flop into the bit cell.
  - s = a0^b0^c; c' = (a0&b0)|(c&(a0^b0)).
  - Shift s into the sum register from the MSB end (LSB-first arithmetic).
  - Shift both operand registers right by one and register c'.
  - Increment the counter. After the cycle where the counter equals WIDTH-1, go to DONE with cout=c'.
- DONE: out_valid=1. sum/cout are held stable until out_ready=1 at an edge, then go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, mod 2^(WIDTH+1). No sign interpretation.
- Boundary cases:
  - in_valid during SHIFT or DONE is ignored; in_ready=0, and the upstream must hold its data.
  - out_ready while not in DONE has no effect.
  - In DONE with out_ready=1 and in_valid=1 in the same cycle, the FSM goes to IDLE only. The new operands are accepted no earlier than the following cycle, so there is no bypass.
  - Operand values are sampled only at the accept edge. Later changes to a/b/cin do not affect the result.
- Reset (any state, including mid-SHIFT): FSM=IDLE, and counter, shift registers, carry, sum and cout all clear to 0. A partial result is discarded, never presented.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Accept at edge N. busy=1 during cycles N+1..N+WIDTH. out_valid=1 from edge N+WIDTH onward.
- Latency from accept edge to out_valid is WIDTH cycles; for WIDTH=4 this is 4 cycles.
- Minimum issue interval is WIDTH+2 cycles when out_ready is held high: accept, WIDTH shift cycles, DONE, then IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous reset takes effect immediately. Deassertion is synchronised externally.

## Configuration
- SERIAL_ADD_SAT_EN:
  - Defined: when the final carry is 1, the value loaded in DONE is sum = all ones, and cout is still reported as 1 (saturating add).
  - Undefined: sum wraps (mod 2^WIDTH), and cout carries the overflow.
  - Only the DONE-entry load changes. FSM and timing are identical in both builds.

## Test plan
- Reset, then a=4'h3, b=4'h4, cin=0 -> out_valid exactly 4 cycles after accept, with sum=4'h7, cout=0.
- a=4'hF, b=4'h1, cin=1, with the macro undefined -> sum=4'h1, cout=1. With SERIAL_ADD_SAT_EN defined -> sum=4'hF, cout=1.
- Hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands -> sum/cout stable, in_ready=0, no second accept. Release out_ready -> IDLE, and the next accept occurs one cycle later.
- Assert rst during SHIFT (after 2 bits) -> all outputs at reset values immediately. A new a=4'h9, b=4'h9, cin=0 after release -> sum=4'h2, cout=1.
- Exhaustive sweep: all 512 (a,b,cin) combinations for WIDTH=4, each compared against a+b+cin as {cout,sum}. Zero mismatches and fixed 4-cycle latency.
- Change a/b mid-SHIFT -> result reflects only the operands sampled at the accept edge.
